rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single write port of the SPU register file among NREQ writeback requesters using round-robin arbitration. It also provides a bulk-initialise sequencer that writes a programmable value into every register-file entry, one entry per cycle. It sits between the execution/writeback units and the register file's w_en/w_addr/w_data inputs. All write-port outputs are registered.

## Interface
- NREQ, 4: number of write requesters, 2..8
- IDW, 2: grant-index width, ceil(log2(NREQ))
- DEPTH, 16: register-file entries; DEPTH ≤ 2^ADDR
- ADDR, 4: register address width
- WIDTH, 16: data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*ADDR  packed addresses; requester i at [i*ADDR +: ADDR]
- req_data  in  NREQ*WIDTH  packed data; requester i at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept, combinational
- init_start  in  1  starts the bulk-initialise sequence
- init_value  in  WIDTH  value written by the initialise sequence; captured when init_start is accepted
- init_busy  out  1  high while in state INIT
- init_done  out  1  one-cycle pulse coincident with the last initialise write
- w_en  out  1  write enable to the register file, registered
- w_addr  out  ADDR  write address, registered
- w_data  out  WIDTH  write data, registered
- grant_id  out  IDW  index of the requester whose write is on the port, registered; 0 when idle

## Operation
- FSM states: ARB and INIT. Reset state is ARB.
- **ARB, init_start low:**
  - Round-robin search over req_valid, starting at pointer ptr.
  - The first valid index g receives req_ready[g]=1; all other ready bits are 0.
  - Transfer occurs when req_valid[g] and req_ready[g] are both high.
  - On a transfer, the next edge registers w_en=1, w_addr=req_addr[g], w_data=req_data[g], grant_id=g, and sets ptr=(g+1) mod NREQ.
  - With no valid requests: w_en=0, grant_id=0, ptr unchanged.
- **ARB, init_start high:**
  - init_start has priority; req_ready is all 0 that cycle.
  - The next edge captures init_value, sets cnt=0, enters INIT, and registers w_en=0.
- **INIT:**
  - req_ready is all 0; init_start is ignored.
  - Each edge registers w_en=1, w_addr=cnt, w_data=captured value, grant_id=0.
  - If cnt==DEPTH-1: registers init_done=1 and returns to ARB. Otherwise cnt increments.
  - ptr is unchanged across INIT.
- Requesters hold req_valid, req_addr and req_data stable until accepted. Dropping req_valid without acceptance is allowed and has no effect.
- Multiple requesters may target the same address. They are serviced in grant order, so the later grant wins.
- init_busy = (state==INIT).
- init_done is high for exactly one cycle; it is 0 in all other cycles.
- **Reset (any time, including mid-INIT):**
  - Outputs go immediately to w_en=0, w_addr=0, w_data=0, grant_id=0, init_done=0, init_busy=0, req_ready=0.
  - Internal state: ptr=0, cnt=0, state=ARB.
  - An aborted INIT produces no init_done.

## Timing
- Request latency: accepted at edge E; write visible on the port during the cycle after E; register file captures it at edge E+1.
- Throughput: one write per cycle. With all requesters continuously valid, each requester is granted once every NREQ cycles.
- init_start sampled at edge E0:
  - Writes to addresses 0..DEPTH-1 are on the port in the cycles following edges E1..E_DEPTH.
  - init_done is high in the cycle after E_DEPTH, together with the address DEPTH-1 write.
  - init_busy is high from E0 until E_DEPTH.
- First requester grant after INIT is possible in the cycle after E_DEPTH. Its write appears after edge E_DEPTH+1, giving no gap on the port.
- When init_start and requests arrive in the same cycle, INIT wins. Pending requests are served afterwards, starting from the unchanged ptr.

## Test plan
- **Reset values:** assert rst mid-cycle -> all outputs 0 immediately. Release rst, drive idle inputs -> w_en stays 0.
- **Single requester:** req_valid=4'b0100, addr 5, data 16'h1234 -> req_ready=4'b0100 same cycle; next cycle w_en=1, w_addr=5, w_data=16'h1234, grant_id=2.
- **Round-robin order:** all four requesters valid and held after reset -> grant_id sequence 0,1,2,3,0 on consecutive cycles.
- **Pointer after grant:** after a grant to 2, assert req_valid=4'b1001 -> requester 3 granted first, then requester 0.
- **Initialise with pending requests:** init_start with init_value=16'hA5A5 while req_valid=4'b0011, DEPTH=16 -> ready all 0 for 17 cycles. Sixteen writes occur to addresses 0..15 with data A5A5. init_done pulses with the address-15 write. Requester 0 is then granted, then requester 1, with no idle port cycle.
- **Reset mid-INIT:** assert rst when w_addr=7 during INIT -> outputs return to 0. No init_done. After release, state is ARB and a request is granted normally.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a
// bulk-initialise sequencer that fills every entry with a captured value.
module rf_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  init_start,
    input  logic [WIDTH-1:0]      init_value,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  w_en,
    output logic [ADDR-1:0]       w_addr,
    output logic [WIDTH-1:0]      w_data,
    output logic [IDW-1:0]        grant_id
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [ADDR-1:0]  r_cnt;
    logic [ADDR-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] w_val_nxt;

    logic             r_w_en;
    logic             w_en_nxt;
    logic [ADDR-1:0]  r_w_addr;
    logic [ADDR-1:0]  w_addr_nxt;
    logic [WIDTH-1:0] r_w_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [IDW-1:0]   r_gid;
    logic [IDW-1:0]   w_gid_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    logic [IDW:0]     w_idx;
    logic             w_arb_ok;
    logic             w_last;

    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    // Handshake: a requester transfers in the cycle where its req_valid and
    // req_ready are both high; ready is one-hot, only in ARB, and yields to
    // init_start.
    assign w_arb_ok  = (r_state == ST_ARB) && !init_start && !rst;
    assign req_ready = (w_arb_ok && w_found) ? (NREQ'(1) << w_gnt) : '0;
    assign w_last    = (r_cnt == ADDR'(DEPTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_val_nxt   = r_val;
        w_en_nxt    = 1'b0;
        w_addr_nxt  = r_w_addr;
        w_data_nxt  = r_w_data;
        w_gid_nxt   = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (init_start) begin
                    w_val_nxt   = init_value;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_INIT;
                end else if (w_found) begin
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = req_addr[int'(w_gnt)*ADDR +: ADDR];
                    w_data_nxt = req_data[int'(w_gnt)*WIDTH +: WIDTH];
                    w_gid_nxt  = w_gnt;
                    w_ptr_nxt  = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);
                end
            end
            ST_INIT: begin
                w_en_nxt   = 1'b1;
                w_addr_nxt = r_cnt;
                w_data_nxt = r_val;
                if (w_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_ARB;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ARB;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_val    <= '0;
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
            r_gid    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_val    <= w_val_nxt;
            r_w_en   <= w_en_nxt;
            r_w_addr <= w_addr_nxt;
            r_w_data <= w_data_nxt;
            r_gid    <= w_gid_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign w_en      = r_w_en;
    assign w_addr    = r_w_addr;
    assign w_data    = r_w_data;
    assign grant_id  = r_gid;
    assign init_done = r_done;
    assign init_busy = (r_state == ST_INIT);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written INIT/reset
// sequences, and a randomized run against a cycle-level reference model.
module tb_rf_write_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;
    localparam int WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADDR-1:0]  req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  init_start;
    logic [WIDTH-1:0]      init_value;
    logic                  init_busy;
    logic                  init_done;
    logic                  w_en;
    logic [ADDR-1:0]       w_addr;
    logic [WIDTH-1:0]      w_data;
    logic [IDW-1:0]        grant_id;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH), .ADDR(ADDR), .WIDTH(WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .init_start(init_start), .init_value(init_value),
        .init_busy(init_busy), .init_done(init_done),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .grant_id(grant_id)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w_en"},      64'(w_en), 64'd0);
        chk({tag, "_w_addr"},    64'(w_addr), 64'd0);
        chk({tag, "_w_data"},    64'(w_data), 64'd0);
        chk({tag, "_grant_id"},  64'(grant_id), 64'd0);
        chk({tag, "_init_done"}, 64'(init_done), 64'd0);
        chk({tag, "_init_busy"}, 64'(init_busy), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    task automatic drive_idle();
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        init_start = 1'b0;
        init_value = '0;
    endtask

    // Reference model: spec-level view of arbiter state.
    int               m_ptr;
    bit               m_init;
    int               m_cnt;
    logic [WIDTH-1:0] m_val;
    logic             e_en;
    logic [ADDR-1:0]  e_addr;
    logic [WIDTH-1:0] e_data;
    int               e_gid;
    logic             e_done;

    function automatic int m_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready(input logic [NREQ-1:0] v, input logic st);
        int g;
        if (m_init || st) return '0;
        g = m_pick(v);
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    task automatic m_edge();
        int g;
        e_en = 1'b0; e_gid = 0; e_done = 1'b0;
        if (m_init) begin
            e_en = 1'b1; e_addr = ADDR'(m_cnt); e_data = m_val;
            if (m_cnt == DEPTH - 1) begin
                e_done = 1'b1; m_init = 1'b0;
            end else begin
                m_cnt++;
            end
        end else if (init_start) begin
            m_val = init_value; m_cnt = 0; m_init = 1'b1;
        end else begin
            g = m_pick(req_valid);
            if (g >= 0) begin
                e_en = 1'b1; e_gid = g;
                e_addr = req_addr[g*ADDR +: ADDR];
                e_data = req_data[g*WIDTH +: WIDTH];
                m_ptr = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_init = 1'b0; m_cnt = 0; m_val = '0;
    endtask

    typedef struct {
        logic [NREQ-1:0]       valid;
        logic [NREQ*ADDR-1:0]  addr;
        logic [NREQ*WIDTH-1:0] data;
        logic [NREQ-1:0]       exp_ready;
        logic                  exp_en;
        logic [ADDR-1:0]       exp_addr;
        logic [WIDTH-1:0]      exp_data;
        logic [IDW-1:0]        exp_gid;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b1111, 16'h3210, 64'h4444_3333_2222_1111, 4'b0001, 1'b1, 4'h0, 16'h1111, 2'd0};
        vecs[1]  = '{4'b1111, 16'h3210, 64'h4444_3333_2222_1111, 4'b0010, 1'b1, 4'h1, 16'h2222, 2'd1};
        vecs[2]  = '{4'b1111, 16'h3210, 64'h4444_3333_2222_1111, 4'b0100, 1'b1, 4'h2, 16'h3333, 2'd2};
        vecs[3]  = '{4'b1111, 16'h3210, 64'h4444_3333_2222_1111, 4'b1000, 1'b1, 4'h3, 16'h4444, 2'd3};
        vecs[4]  = '{4'b1111, 16'h3210, 64'h4444_3333_2222_1111, 4'b0001, 1'b1, 4'h0, 16'h1111, 2'd0};
        vecs[5]  = '{4'b0000, 16'h0000, 64'h0,                   4'b0000, 1'b0, 4'h0, 16'h0000, 2'd0};
        vecs[6]  = '{4'b0100, 16'h0500, 64'h0000_1234_0000_0000, 4'b0100, 1'b1, 4'h5, 16'h1234, 2'd2};
        vecs[7]  = '{4'b1001, 16'h9001, 64'hDDDD_0000_0000_AAAA, 4'b1000, 1'b1, 4'h9, 16'hDDDD, 2'd3};
        vecs[8]  = '{4'b0001, 16'h9001, 64'hDDDD_0000_0000_AAAA, 4'b0001, 1'b1, 4'h1, 16'hAAAA, 2'd0};
        vecs[9]  = '{4'b0011, 16'h0076, 64'h0000_0000_7777_6666, 4'b0010, 1'b1, 4'h7, 16'h7777, 2'd1};
        vecs[10] = '{4'b0011, 16'h0076, 64'h0000_0000_7777_6666, 4'b0001, 1'b1, 4'h6, 16'h6666, 2'd0};
        vecs[11] = '{4'b0000, 16'h0000, 64'h0,                   4'b0000, 1'b0, 4'h0, 16'h0000, 2'd0};

        rst = 1'b1;
        drive_idle();
        #12;
        chk_all_zero("por");
        do_reset();

        // Directed table: round-robin, idle, single requester, pointer order.
        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].valid;
            req_addr  = vecs[i].addr;
            req_data  = vecs[i].data;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_w_en", i), 64'(w_en), 64'(vecs[i].exp_en));
            chk($sformatf("vec%0d_gid", i), 64'(grant_id), 64'(vecs[i].exp_gid));
            if (vecs[i].exp_en) begin
                chk($sformatf("vec%0d_addr", i), 64'(w_addr), 64'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_data", i), 64'(w_data), 64'(vecs[i].exp_data));
            end
            chk($sformatf("vec%0d_done", i), 64'(init_done), 64'd0);
            @(negedge clk);
        end

        // Reset asserted mid-cycle while a write is on the port.
        req_valid = 4'b0001; req_addr = 16'h000C; req_data = 64'h0000_0000_0000_BEEF;
        @(posedge clk); #1;
        chk("pre_rst_w_en", 64'(w_en), 64'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        chk("post_rst_idle_w_en", 64'(w_en), 64'd0);
        @(negedge clk);

        // INIT with pending requests 0 and 1; ptr is 0 after reset.
        req_valid = 4'b0011; req_addr = 16'h0032; req_data = 64'h0000_0000_BBBB_CCCC;
        init_start = 1'b1; init_value = 16'hA5A5;
        #1 chk("init_start_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("init_e0_w_en", 64'(w_en), 64'd0);
        chk("init_e0_busy", 64'(init_busy), 64'd1);
        @(negedge clk);
        init_start = 1'b0; init_value = 16'h0000;
        for (int k = 0; k < DEPTH; k++) begin
            init_start = (k == 5);
            #1 chk($sformatf("init%0d_ready", k), 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("init%0d_w_en", k), 64'(w_en), 64'd1);
            chk($sformatf("init%0d_addr", k), 64'(w_addr), 64'(k));
            chk($sformatf("init%0d_data", k), 64'(w_data), 64'hA5A5);
            chk($sformatf("init%0d_gid", k), 64'(grant_id), 64'd0);
            chk($sformatf("init%0d_done", k), 64'(init_done), 64'(k == DEPTH - 1));
            chk($sformatf("init%0d_busy", k), 64'(init_busy), 64'(k != DEPTH - 1));
            @(negedge clk);
        end
        init_start = 1'b0;
        #1 chk("post_init_ready0", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        chk("post_init_g0_w_en", 64'(w_en), 64'd1);
        chk("post_init_g0_addr", 64'(w_addr), 64'h2);
        chk("post_init_g0_data", 64'(w_data), 64'hCCCC);
        chk("post_init_g0_gid", 64'(grant_id), 64'd0);
        chk("post_init_g0_done", 64'(init_done), 64'd0);
        @(negedge clk);
        req_valid = 4'b0010;
        #1 chk("post_init_ready1", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        chk("post_init_g1_w_en", 64'(w_en), 64'd1);
        chk("post_init_g1_addr", 64'(w_addr), 64'h3);
        chk("post_init_g1_data", 64'(w_data), 64'hBBBB);
        chk("post_init_g1_gid", 64'(grant_id), 64'd1);
        @(negedge clk);
        drive_idle();

        // Reset during INIT once address 7 is on the port.
        init_start = 1'b1; init_value = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        init_start = 1'b0;
        for (int k = 0; k < 8; k++) @(posedge clk);
        #1 chk("abort_addr7", 64'(w_addr), 64'd7);
        #2 rst = 1'b1;
        #1 chk_all_zero("abort_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_quiet%0d_done", k), 64'(init_done), 64'd0);
            chk($sformatf("abort_quiet%0d_w_en", k), 64'(w_en), 64'd0);
            chk($sformatf("abort_quiet%0d_busy", k), 64'(init_busy), 64'd0);
            @(negedge clk);
        end
        req_valid = 4'b1111; req_addr = 16'h3210; req_data = 64'h4444_3333_2222_1111;
        #1 chk("abort_after_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        chk("abort_after_w_en", 64'(w_en), 64'd1);
        chk("abort_after_gid", 64'(grant_id), 64'd0);
        chk("abort_after_data", 64'(w_data), 64'h1111);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_addr   = 16'($urandom);
            req_data   = {$urandom, $urandom};
            init_start = ($urandom_range(0, 29) == 0);
            init_value = 16'($urandom);
            #1 chk($sformatf("rnd%0d_ready", c), 64'(req_ready), 64'(m_ready(req_valid, init_start)));
            @(posedge clk);
            m_edge();
            #1;
            chk($sformatf("rnd%0d_w_en", c), 64'(w_en), 64'(e_en));
            chk($sformatf("rnd%0d_gid", c), 64'(grant_id), 64'(e_gid));
            chk($sformatf("rnd%0d_done", c), 64'(init_done), 64'(e_done));
            chk($sformatf("rnd%0d_busy", c), 64'(init_busy), 64'(m_init));
            if (e_en) begin
                chk($sformatf("rnd%0d_addr", c), 64'(w_addr), 64'(e_addr));
                chk($sformatf("rnd%0d_data", c), 64'(w_data), 64'(e_data));
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
